zero_pad_window_streamer: RTL and testbench

//  Upstream feeder for the zero-padding spatial convolution stage. Accepts one IN_LENGTH x IN_WIDTH

---
 rtl/zero_pad_window_streamer.sv | 158 +++++++++++++++
 tb/tb_zero_pad_window_streamer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/zero_pad_window_streamer.sv
// Buffers a raster pixel stream in a circular line store and emits one
// zero-padded KxK window per frame pixel, in raster order.
module zero_pad_window_streamer #(
    parameter int BIT_REP_IN  = 8,
    parameter int IN_LENGTH   = 8,
    parameter int IN_WIDTH    = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [BIT_REP_IN-1:0]                          in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BIT_REP_IN-1:0] out_window,
    output logic [$clog2(IN_LENGTH)-1:0]                   out_row,
    output logic [$clog2(IN_WIDTH)-1:0]                    out_col,
    output logic                                           out_last
);

    localparam int B    = BIT_REP_IN;
    localparam int H    = IN_LENGTH;
    localparam int W    = IN_WIDTH;
    localparam int K    = KERNEL_SIZE;
    localparam int P    = (K - 1) / 2;
    localparam int NR   = 2 * P + 1;
    localparam int NPIX = H * W;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int RW   = $clog2(H);
    localparam int CLW  = $clog2(W);
    localparam int SW   = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic {
        WAIT,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]  in_cnt;
    logic [RW-1:0]  cur_r;
    logic [CLW-1:0] cur_c;
    logic [SW-1:0]  cur_slot;
    logic [CLW-1:0] wr_col;
    logic [SW-1:0]  wr_slot;
    logic [B-1:0]   mem [NR][W];

    logic [CW-1:0]      need_row, need_col, need;
    logic               in_fire, out_fire, load, is_last;
    logic [K*K*B-1:0]   win_nxt;

    // Last raster index the current window depends on, clamped at the frame edge.
    always_comb begin
        need_row = CW'(cur_r) + CW'(P);
        need_col = CW'(cur_c) + CW'(P);
        if (int'(cur_r) + P > H - 1) need_row = CW'(H - 1);
        if (int'(cur_c) + P > W - 1) need_col = CW'(W - 1);
        need = need_row * CW'(W) + need_col;
    end

    assign in_ready  = (in_cnt < CW'(NPIX)) && (in_cnt <= need);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign out_fire  = out_valid && out_ready;
    assign load      = (state == WAIT) && (in_cnt > need);
    assign is_last   = (cur_r == RW'(H - 1)) && (cur_c == CLW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT: if (load) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    // Window rows map to line-store slots relative to the centre row's slot.
    always_comb begin
        int rr, cc, s;
        rr = 0;
        cc = 0;
        s  = 0;
        win_nxt = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rr = int'(cur_r) + i - P;
                cc = int'(cur_c) + j - P;
                s  = int'(cur_slot) + i - P;
                if (s < 0) s = s + NR;
                else if (s >= NR) s = s - NR;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    win_nxt[(i*K+j)*B +: B] = mem[SW'(s)][CLW'(cc)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem[wr_slot][wr_col] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt   <= '0;
            cur_r    <= '0;
            cur_c    <= '0;
            cur_slot <= '0;
            wr_col   <= '0;
            wr_slot  <= '0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + 1'b1;
                if (wr_col == CLW'(W - 1)) begin
                    wr_col  <= '0;
                    wr_slot <= (wr_slot == SW'(NR - 1)) ? '0 : wr_slot + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
            if (out_fire) begin
                if (out_last) begin
                    in_cnt   <= '0;
                    cur_r    <= '0;
                    cur_c    <= '0;
                    cur_slot <= '0;
                    wr_col   <= '0;
                    wr_slot  <= '0;
                end else if (cur_c == CLW'(W - 1)) begin
                    cur_c    <= '0;
                    cur_r    <= cur_r + 1'b1;
                    cur_slot <= (cur_slot == SW'(NR - 1)) ? '0 : cur_slot + 1'b1;
                end else begin
                    cur_c <= cur_c + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
        end else if (load) begin
            out_window <= win_nxt;
            out_row    <= cur_r;
            out_col    <= cur_c;
            out_last   <= is_last;
        end
    end

endmodule

// File: tb/tb_zero_pad_window_streamer.sv
// Directed and gapped-traffic checks of zero_pad_window_streamer
// on a 4x4 frame with a 3x3 kernel.
module tb_zero_pad_window_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_window;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;
    int pix [16];
    logic [71:0] got [16];

    zero_pad_window_streamer #(
        .BIT_REP_IN (8),
        .IN_LENGTH  (4),
        .IN_WIDTH   (4),
        .KERNEL_SIZE(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_window(out_window),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs,
                         input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pk(int a, int b, int c, int d, int e,
                                       int f, int g, int h, int i);
        return {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [71:0] model_win(int r, int c);
        logic [71:0] w;
        int rr, cc, v;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + i - 1;
                cc = c + j - 1;
                v = (rr >= 0 && rr < 4 && cc >= 0 && cc < 4) ? pix[rr*4+cc] : 0;
                w[(i*3+j)*8 +: 8] = 8'(v);
            end
        end
        return w;
    endfunction

    task automatic seq_frame();
        for (int n = 0; n < 16; n++) pix[n] = n + 1;
    endtask

    task automatic producer(input int gaps, input int count);
        int n, cyc;
        logic hs;
        n = 0;
        cyc = 0;
        while (n < count && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = 8'(pix[n]);
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (n < count) check("feed_timeout", 72'(n), 72'(count));
    endtask

    task automatic consumer(input int gaps, input int hold_k);
        int k, cyc, held;
        k = 0;
        cyc = 0;
        held = 0;
        while (k < 16 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (out_valid && k == hold_k && held < 10) begin
                out_ready = 1'b0;
                held++;
                check("hold_win", out_window, pk(0, 0, 0, 1, 2, 3, 5, 6, 7));
                check("hold_in_ready", 72'(in_ready), 72'(0));
                check("hold_col", 72'(out_col), 72'(1));
            end else begin
                out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (out_valid && out_ready) begin
                check("win", out_window, model_win(k / 4, k % 4));
                check("row", 72'(out_row), 72'(k / 4));
                check("col", 72'(out_col), 72'(k % 4));
                check("last", 72'(out_last), 72'(k == 15));
                if (k == 0) check("in_ready_while_out", 72'(in_ready), 72'(0));
                got[k] = out_window;
                k++;
            end
        end
        if (k < 16) check("drain_timeout", 72'(k), 72'(16));
    endtask

    task automatic run_frame(input int gaps, input int hold_k);
        fork
            producer(gaps, 16);
            consumer(gaps, hold_k);
        join
    endtask

    task automatic reset_mid_cycle(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, "_out_valid"}, 72'(out_valid), 72'(0));
        check({tag, "_out_window"}, out_window, 72'(0));
        check({tag, "_in_ready"}, 72'(in_ready), 72'(1));
        check({tag, "_out_last"}, 72'(out_last), 72'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_out_window", out_window, 72'(0));
        check("rst_in_ready", 72'(in_ready), 72'(1));
        check("rst_row_col", 72'({out_row, out_col}), 72'(0));
        @(negedge clk);
        rst = 1'b0;

        seq_frame();
        run_frame(0, -1);
        check("first_win", got[0], pk(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("win_1_2", got[6], pk(2, 3, 4, 6, 7, 8, 10, 11, 12));
        check("win_3_3", got[15], pk(11, 12, 0, 15, 16, 0, 0, 0, 0));

        run_frame(0, 1);
        check("win_0_1_after_hold", got[1], pk(0, 0, 0, 1, 2, 3, 5, 6, 7));

        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 16; n++) pix[n] = int'($urandom_range(0, 255)) - 128;
            run_frame(1, -1);
        end

        seq_frame();
        out_ready = 1'b1;
        producer(0, 9);
        reset_mid_cycle("rst2");
        run_frame(0, -1);
        check("restart_first_win", got[0], pk(0, 0, 0, 0, 1, 2, 0, 5, 6));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
